// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI slave receive path: pin synchronisers, CPOL/CPHA deserialiser, output FIFO
// Optional feature macro: SPI_RX_FRAME_TAG_EN adds a per-word first-of-frame tag and the rx_first port.
module spi_slave_rx #(
  parameter int DW          = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sck,
  input  logic                          mosi,
  input  logic                          cs_n,
  input  logic                          cpol,
  input  logic                          cpha,
  output logic [DW-1:0]                 rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clr_overrun
`ifdef SPI_RX_FRAME_TAG_EN
  ,
  output logic                          rx_first
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DW);
`ifdef SPI_RX_FRAME_TAG_EN
  localparam int FW = DW + 1;
`else
  localparam int FW = DW;
`endif

  typedef enum logic {IDLE, ACTIVE} state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronisers and edge history
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sck_s, mosi_s, cs_s;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  // Shift raw pins through the synchroniser chains; remember last synced level for edges
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
  end

  // Synchroniser registers; history flops reset like their chains so release is edge-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  logic cs_fall, cs_rise, sck_rise, sck_fall;

  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  // ---------------------------------------------------------------------------
  // Frame FSM and deserialiser
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic            cpol_q, cpol_d;
  logic            cpha_q, cpha_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic [CW-1:0]   bitcnt_q, bitcnt_d;
  logic            frame_err_q, frame_err_d;
  logic            sample_edge;
  logic [DW-1:0]   new_word;
  logic            push;
`ifdef SPI_RX_FRAME_TAG_EN
  logic            first_q, first_d;
`endif

  // Mode 0/3 sample on rising sck, modes 1/2 on falling, using the per-frame latched mode
  assign sample_edge = (cpol_q == cpha_q) ? sck_rise : sck_fall;

  // Word including the bit arriving on this sample edge
  assign new_word = MSB_FIRST ? {shift_q[DW-2:0], mosi_s} : {mosi_s, shift_q[DW-1:1]};

  // Next-state logic: frame start/end on cs_n edges, bit assembly on sample edges
  always_comb begin
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
`ifdef SPI_RX_FRAME_TAG_EN
    first_d     = first_q;
`endif
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d  = ACTIVE;
          cpol_d   = cpol;
          cpha_d   = cpha;
          shift_d  = '0;
          bitcnt_d = '0;
`ifdef SPI_RX_FRAME_TAG_EN
          first_d  = 1'b1;
`endif
        end
      end
      ACTIVE: begin
        // cs_n release takes priority over a coincident sample edge
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = (bitcnt_q != '0);
          shift_d     = '0;
          bitcnt_d    = '0;
        end else if (sample_edge) begin
          shift_d = new_word;
          if (bitcnt_q == CW'(DW - 1)) begin
            push     = 1'b1;
            bitcnt_d = '0;
`ifdef SPI_RX_FRAME_TAG_EN
            first_d  = 1'b0;
`endif
          end else begin
            bitcnt_d = bitcnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      frame_err_q <= 1'b0;
`ifdef SPI_RX_FRAME_TAG_EN
      first_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      frame_err_q <= frame_err_d;
`ifdef SPI_RX_FRAME_TAG_EN
      first_q     <= first_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [FW-1:0]  mem_q [FIFO_DEPTH];
  logic [FW-1:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           overrun_q, overrun_d;
  logic           pop, full, push_ok;
  logic [FW-1:0]  push_word;
  logic [FW-1:0]  head;

`ifdef SPI_RX_FRAME_TAG_EN
  assign push_word = {first_q, new_word};
`else
  assign push_word = new_word;
`endif

  assign pop     = (level_q != '0) & rx_ready;
  assign full    = (level_q == LW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_ok = push & (~full | pop);

  // FIFO pointer, level, storage and overrun update
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A drop in the same cycle as a clear keeps the flag set
    if (push & ~push_ok) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // FIFO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign rx_valid   = (level_q != '0);
  assign rx_data    = rx_valid ? head[DW-1:0] : '0;
  assign fifo_level = level_q;
  assign busy       = (state_q == ACTIVE);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef SPI_RX_FRAME_TAG_EN
  assign rx_first   = rx_valid ? head[DW] : 1'b0;
`endif

endmodule
